// File: rtl/sig_router.sv
// ----------------------------------------------------------------------------
// sig_router
//
// Routes one of NCH source channels (speaker bit, LED bus, 8 seg-display
// nibbles) to the board outputs. Every output is registered. Each channel
// switch inserts a speaker mute gap so the buzzer does not pop. Any select
// value >= NCH selects idle, which shows a banner on the digits.
//
// Optional feature macro: SIG_ROUTER_SCROLL_EN
//   defined   -> the idle banner rotates left one nibble every SCROLL_DIV cycles
//   undefined -> the idle banner is a static IDLE_MSG, no divider logic
//
// Ports:
//   clk        in   1           system clock
//   rst_n      in   1           asynchronous active-low reset
//   sel        in   SEL_W       channel select, >= NCH means idle
//   spk_in     in   NCH         speaker bit per channel (channel i at bit i)
//   led_in     in   NCH*LED_W   LED bus per channel (channel i at [i*LED_W +: LED_W])
//   dig_in     in   NCH*32      digit nibbles per channel (channel i at [i*32 +: 32])
//   speaker    out  1           routed speaker bit, forced low during the gap
//   led        out  LED_W       routed LED bus, 0 when idle
//   digits     out  32          nibbles p7..p0 for seg_display
//   active_ch  out  SEL_W       applied select, NCH when idle
//   muting     out  1           high while the mute gap runs
// ----------------------------------------------------------------------------
module sig_router #(
   parameter int          NCH         = 4,
   parameter int          SEL_W       = 3,
   parameter int          LED_W       = 8,
   parameter int          MUTE_CYCLES = 1000,
   parameter logic [31:0] IDLE_MSG    = 32'h6E77_0DDD,
   parameter int          SCROLL_DIV  = 50_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SEL_W-1:0]     sel,
   input  logic [NCH-1:0]       spk_in,
   input  logic [NCH*LED_W-1:0] led_in,
   input  logic [NCH*32-1:0]    dig_in,
   output logic                 speaker,
   output logic [LED_W-1:0]     led,
   output logic [31:0]          digits,
   output logic [SEL_W-1:0]     active_ch,
   output logic                 muting
);

   // Elaboration-time parameter sanity checks.
   if (NCH < 1 || NCH > 7) begin : g_bad_nch
      $error("sig_router: NCH must be in 1..7");
   end
   if ((2 ** SEL_W) <= NCH) begin : g_bad_sel_w
      $error("sig_router: SEL_W too narrow to encode the idle select");
   end
   if (MUTE_CYCLES < 0) begin : g_bad_mute
      $error("sig_router: MUTE_CYCLES must be >= 0");
   end
   if (SCROLL_DIV < 1) begin : g_bad_div
      $error("sig_router: SCROLL_DIV must be >= 1");
   end

   localparam logic [SEL_W-1:0] IDLE_SEL = SEL_W'(NCH);
   localparam int               CNT_W    = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_CYCLES - 1);

   typedef enum logic {
      RUN  = 1'b0,
      MUTE = 1'b1
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [SEL_W-1:0]   sel_q, sel_n;
   logic               changed, idle_n;

   logic               spk_sel;
   logic [LED_W-1:0]   led_sel;
   logic [31:0]        dig_sel;

   logic               speaker_d;
   logic [LED_W-1:0]   led_d;
   logic [31:0]        digits_d;

`ifdef SIG_ROUTER_SCROLL_EN
   localparam int               DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

   logic [DIV_W-1:0]   div_q, div_d;
   logic [31:0]        banner_q, banner_d;
`endif

   // -------------------------------------------------------------------------
   // Next-state / next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; that is what keeps always_comb from inferring a latch.
      state_d   = state;
      cnt_d     = cnt;
      spk_sel   = 1'b0;
      led_sel   = '0;
      dig_sel   = '0;

      // All idle codes collapse to one value, so hopping between two idle
      // codes never counts as a change.
      sel_n   = (sel >= IDLE_SEL) ? IDLE_SEL : sel;
      changed = (sel_n != sel_q);
      idle_n  = (sel_n == IDLE_SEL);

      // Mux by comparison so an idle select never indexes past the buses.
      for (int i = 0; i < NCH; i++) begin
         if (sel_n == SEL_W'(i)) begin
            spk_sel = spk_in[i];
            led_sel = led_in[i*LED_W +: LED_W];
            dig_sel = dig_in[i*32 +: 32];
         end
      end

      case (state)
         RUN: begin
            if (changed && (MUTE_CYCLES > 0)) begin
               state_d = MUTE;
               cnt_d   = CNT_LOAD;
            end
         end
         MUTE: begin
            if (changed) begin
               cnt_d = CNT_LOAD;  // a new switch restarts the full gap
            end else if (cnt == '0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         default: state_d = RUN;
      endcase

      // Outputs are computed from the next state so they register together
      // with it; spk_sel is already 0 for the idle select.
      speaker_d = (state_d == RUN) ? spk_sel : 1'b0;
      led_d     = led_sel;

`ifdef SIG_ROUTER_SCROLL_EN
      div_d    = div_q;
      banner_d = banner_q;
      if (idle_n) begin
         if (sel_q != IDLE_SEL) begin
            // Entering idle always starts the banner from the top.
            banner_d = IDLE_MSG;
            div_d    = '0;
         end else if (div_q == DIV_LAST) begin
            div_d    = '0;
            banner_d = {banner_q[27:0], banner_q[31:28]};
         end else begin
            div_d    = div_q + DIV_W'(1);
         end
      end
      digits_d = idle_n ? banner_d : dig_sel;
`else
      digits_d = idle_n ? IDLE_MSG : dig_sel;
`endif
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         cnt     <= '0;
         sel_q   <= IDLE_SEL;
         speaker <= 1'b0;
         led     <= '0;
         digits  <= IDLE_MSG;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         sel_q   <= sel_n;
         speaker <= speaker_d;
         led     <= led_d;
         digits  <= digits_d;
      end
   end

`ifdef SIG_ROUTER_SCROLL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         banner_q <= IDLE_MSG;
      end else begin
         div_q    <= div_d;
         banner_q <= banner_d;
      end
   end
`endif

   // sel_q and state are registers themselves, so these outputs stay registered.
   assign active_ch = sel_q;
   assign muting    = (state == MUTE);

endmodule

// File: tb/tb_sig_router.sv
// ----------------------------------------------------------------------------
// tb_sig_router
//
// Directed bench for sig_router with NCH=4, LED_W=8, MUTE_CYCLES=4 and
// SCROLL_DIV=3. Inputs change and outputs are sampled 1 time unit after each
// rising edge. Channel i drives led = 8'h11*(i+1) and digits = 32'h11111111*(i+1).
// ----------------------------------------------------------------------------
module tb_sig_router;

   localparam int          NCH      = 4;
   localparam int          SEL_W    = 3;
   localparam int          LED_W    = 8;
   localparam int          MUTE     = 4;
   localparam logic [31:0] MSG      = 32'h6E77_0DDD;
   localparam int          DIV      = 3;

`ifdef SIG_ROUTER_SCROLL_EN
   localparam logic [31:0] MSG_ROT1 = 32'hE770_DDD6;
   localparam logic [31:0] MSG_ROT2 = 32'h770D_DD6E;
`else
   localparam logic [31:0] MSG_ROT1 = 32'h6E77_0DDD;
   localparam logic [31:0] MSG_ROT2 = 32'h6E77_0DDD;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [SEL_W-1:0]     sel;
   logic [NCH-1:0]       spk_in;
   logic [NCH*LED_W-1:0] led_in;
   logic [NCH*32-1:0]    dig_in;
   logic                 speaker;
   logic [LED_W-1:0]     led;
   logic [31:0]          digits;
   logic [SEL_W-1:0]     active_ch;
   logic                 muting;

   int n_checks = 0;
   int n_fail   = 0;

   sig_router #(
      .NCH(NCH), .SEL_W(SEL_W), .LED_W(LED_W), .MUTE_CYCLES(MUTE),
      .IDLE_MSG(MSG), .SCROLL_DIV(DIV)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .spk_in(spk_in),
      .led_in(led_in), .dig_in(dig_in), .speaker(speaker), .led(led),
      .digits(digits), .active_ch(active_ch), .muting(muting)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks every output of a routed (non-idle) channel at once.
   task automatic check_ch(input string tag, input int ch, input logic spk, input logic mut);
      check({tag, ".speaker"},   32'(speaker),   32'(spk));
      check({tag, ".muting"},    32'(muting),    32'(mut));
      check({tag, ".active_ch"}, 32'(active_ch), 32'(ch));
      check({tag, ".led"},       32'(led),       32'(8'h11 * (ch + 1)));
      check({tag, ".digits"},    digits,         32'h1111_1111 * (ch + 1));
   endtask

   initial begin
      rst_n  = 1'b0;
      sel    = 3'd0;
      spk_in = 4'b0001;
      led_in = {8'h44, 8'h33, 8'h22, 8'h11};
      dig_in = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

      // Reset held for 3 cycles.
      repeat (3) step();
      check("rst.speaker",   32'(speaker),   32'd0);
      check("rst.led",       32'(led),       32'd0);
      check("rst.digits",    digits,         MSG);
      check("rst.active_ch", 32'(active_ch), 32'(NCH));
      check("rst.muting",    32'(muting),    32'd0);

      // Release with sel=0: sel_q held idle, so this is a change and a gap.
      rst_n = 1'b1;
      for (int i = 1; i <= MUTE; i++) begin
         step();
         check_ch($sformatf("rel.gap%0d", i), 0, 1'b0, 1'b1);
      end
      step();
      check_ch("rel.run", 0, 1'b1, 1'b0);

      // Go idle via code 5, let the gap finish.
      sel = 3'd5;
      step();
      check("idle5.led",       32'(led),       32'd0);
      check("idle5.digits",    digits,         MSG);
      check("idle5.active_ch", 32'(active_ch), 32'(NCH));
      check("idle5.muting",    32'(muting),    32'd1);
      repeat (MUTE) step();
      check("idle5.endgap",    32'(muting),    32'd0);
      check("idle5.speaker",   32'(speaker),   32'd0);

      // Switch 5 -> 1 with spk_in=0010.
      spk_in = 4'b0010;
      sel    = 3'd1;
      for (int i = 1; i <= MUTE; i++) begin
         step();
         check_ch($sformatf("sw1.gap%0d", i), 1, 1'b0, 1'b1);
      end
      step();
      check_ch("sw1.run", 1, 1'b1, 1'b0);

      // Re-trigger: 1 -> 2, then 2 -> 3 after the third gap cycle.
      spk_in = 4'b1100;
      sel    = 3'd2;
      for (int i = 1; i <= 3; i++) begin
         step();
         check_ch($sformatf("rt.gap%0d", i), 2, 1'b0, 1'b1);
      end
      sel = 3'd3;
      for (int i = 1; i <= MUTE; i++) begin
         step();
         check_ch($sformatf("rt.regap%0d", i), 3, 1'b0, 1'b1);
      end
      step();
      check_ch("rt.run", 3, 1'b1, 1'b0);

      // Idle via code 6, then hop to code 7 (not a change), watch the banner.
      sel = 3'd6;
      step();                                           // entry edge
      check("idle6.led",       32'(led),       32'd0);
      check("idle6.digits",    digits,         MSG);
      check("idle6.active_ch", 32'(active_ch), 32'(NCH));
      check("idle6.speaker",   32'(speaker),   32'd0);
      sel = 3'd7;
      step();                                           // entry + 1
      check("idle7.muting",    32'(muting),    32'd1);
      check("idle7.active_ch", 32'(active_ch), 32'(NCH));
      step();                                           // entry + 2
      step();                                           // entry + 3
      check("scroll.1",        digits,         MSG_ROT1);
      check("idle7.muting_run", 32'(muting),   32'd1);
      step();                                           // entry + 4
      check("idle7.gap_done",  32'(muting),    32'd0);
      check("idle7.speaker",   32'(speaker),   32'd0);
      check("idle7.led",       32'(led),       32'd0);
      step();
      step();                                           // entry + 6
      check("scroll.2",        digits,         MSG_ROT2);

      // Reset mid-gap: idle -> 0, pull reset on the second gap cycle.
      spk_in = 4'b0001;
      sel    = 3'd0;
      step();
      step();
      check_ch("mid.gap2", 0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid.muting",    32'(muting),    32'd0);
      check("mid.digits",    digits,         MSG);
      check("mid.led",       32'(led),       32'd0);
      check("mid.speaker",   32'(speaker),   32'd0);
      check("mid.active_ch", 32'(active_ch), 32'(NCH));
      step();
      rst_n = 1'b1;
      step();
      check("post.muting",   32'(muting),    32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
